// File: rtl/spike_input_source.sv
// Buffers host spike indices in a FIFO and issues them as a registered request/ack handshake; request rises 2 edges after a push into an empty FIFO.
// Back-pressure: push_ready drops only when the FIFO is full; the entry under request stays queued until acked, then one return-to-zero cycle.
module spike_input_source #(
    parameter int SR_DEPTH   = 16384,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int IW        = $clog2(SR_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_valid,
    input  logic [IW-1:0]        push_index,
    output logic                 push_ready,
    output logic                 input_occurred,
    output logic [IW-1:0]        input_index,
    input  logic                 input_ack,
    output logic                 busy,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] sent_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, load;

    assign push_ready = (count < FULL);
    assign push       = push_valid & push_ready;
    assign busy       = (count != '0) | (state != IDLE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // The head is only retired on ack, so it cannot change under an open request.
                if (input_ack) begin
                    pop       = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_index;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            input_occurred <= 1'b0;
            input_index    <= '0;
            overflow       <= 1'b0;
            sent_count     <= '0;
        end else begin
            if (load) begin
                input_occurred <= 1'b1;
                input_index    <= mem[rd_ptr];
            end else if (pop) begin
                input_occurred <= 1'b0;
            end
            if (push_valid & ~push_ready) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                sent_count <= sent_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spike_input_source.sv
// Randomized and directed stimulus for spike_input_source, checked every cycle against a queue-based protocol model.
module tb_spike_input_source;
    localparam int SR_DEPTH   = 16384;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_WIDTH  = 8;
    localparam int IW         = $clog2(SR_DEPTH);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 push_valid;
    logic [IW-1:0]        push_index;
    logic                 push_ready;
    logic                 input_occurred;
    logic [IW-1:0]        input_index;
    logic                 input_ack;
    logic                 busy;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] sent_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: queue of accepted indices (head is the one under request),
    // request flag, return-to-zero holdoff, delivered total, sticky overflow.
    int q[$];
    bit req_m;
    int hold_m;
    int sent_m;
    bit ovf_m;
    int age_m;

    always #5 clk = ~clk;

    spike_input_source #(
        .SR_DEPTH  (SR_DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push_valid    (push_valid),
        .push_index    (push_index),
        .push_ready    (push_ready),
        .input_occurred(input_occurred),
        .input_index   (input_index),
        .input_ack     (input_ack),
        .busy          (busy),
        .overflow      (overflow),
        .sent_count    (sent_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        req_m  = 1'b0;
        hold_m = 0;
        sent_m = 0;
        ovf_m  = 1'b0;
        age_m  = 0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":occurred"},   32'(input_occurred), 32'(req_m));
        if (req_m) chk({ph, ":index"}, 32'(input_index), q[0]);
        chk({ph, ":sent_count"}, 32'(sent_count), 32'(sent_m % (1 << CNT_WIDTH)));
        chk({ph, ":overflow"},   32'(overflow), 32'(ovf_m));
        chk({ph, ":push_ready"}, 32'(push_ready), 32'(q.size() < FIFO_DEPTH));
        chk({ph, ":busy"},       32'(busy), 32'(q.size() != 0 || req_m || hold_m > 0));
    endtask

    task automatic cycle(input string ph, input bit pv, input logic [IW-1:0] pidx, input bit ack);
        bit acc;
        bit was_empty;
        push_valid = pv;
        push_index = pidx;
        input_ack  = ack;
        acc        = pv && (q.size() < FIFO_DEPTH);
        if (pv && !acc) ovf_m = 1'b1;
        was_empty  = (q.size() == 0);
        @(posedge clk);
        if (req_m) begin
            age_m++;
            if (ack) begin
                void'(q.pop_front());
                sent_m++;
                req_m  = 1'b0;
                hold_m = 1;
            end
        end else if (hold_m > 0) begin
            hold_m--;
        end else if (!was_empty) begin
            req_m = 1'b1;
            age_m = 0;
        end
        if (acc) q.push_back(int'(pidx));
        #1;
        check_all(ph);
    endtask

    initial begin
        bit            pv;
        bit            ak;
        logic [IW-1:0] idx;

        reset      = 1'b0;
        push_valid = 1'b0;
        push_index = '0;
        input_ack  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        chk("reset_hold:index", 32'(input_index), 32'd0);
        reset = 1'b1;
        cycle("reset_idle", 1'b0, '0, 1'b0);

        // Single event with ack held high: zero-wait acceptance.
        cycle("single", 1'b1, IW'(14'h1A3), 1'b1);
        repeat (6) cycle("single", 1'b0, '0, 1'b1);

        // Ordered delivery with the ack delayed 4 cycles into each request.
        cycle("order", 1'b1, IW'(5), 1'b0);
        cycle("order", 1'b1, IW'(6), 1'b0);
        cycle("order", 1'b1, IW'(7), 1'b0);
        repeat (30) cycle("order", 1'b0, '0, req_m && age_m >= 3);

        // Fill past capacity without acks, then drain.
        for (int i = 0; i < 9; i++) cycle("full", 1'b1, IW'(100 + i), 1'b0);
        repeat (3) cycle("full_hold", 1'b0, '0, 1'b0);
        repeat (30) cycle("drain", 1'b0, '0, 1'b1);

        // Ack pulses while idle must be ignored.
        repeat (5) cycle("spurious", 1'b0, '0, 1'b1);
        cycle("spurious", 1'b0, '0, 1'b0);

        // Random traffic long enough to wrap the delivered counter and FIFO pointers many times.
        for (int i = 0; i < 1500; i++) begin
            pv  = ($urandom_range(0, 1) == 1);
            idx = IW'($urandom_range(0, SR_DEPTH - 1));
            ak  = ($urandom_range(0, 9) < 7);
            cycle("random", pv, idx, ak);
        end
        repeat (40) cycle("random_drain", 1'b0, '0, 1'b1);

        // Asynchronous reset while a request is open with more queued behind it.
        cycle("midreq", 1'b1, IW'(14'h11), 1'b0);
        cycle("midreq", 1'b1, IW'(14'h22), 1'b0);
        cycle("midreq", 1'b1, IW'(14'h33), 1'b0);
        cycle("midreq", 1'b0, '0, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("midreq_rst");
        chk("midreq_rst:index", 32'(input_index), 32'd0);
        #2 reset = 1'b1;
        repeat (10) cycle("post_rst", 1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
